bht_sat: RTL and testbench
==========================

BHT_SAT -- requirements
Module: bht_sat

Interface
REQ-001 SHALL have parameter M, default 64, meaning number of table entries (power of two, 2..2^PC_W).
REQ-002 SHALL have parameter N, default 2, meaning saturating-counter width in bits (1..4).
REQ-003 SHALL have parameter PC_W, default 9, meaning lookup/update PC width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port lk_valid  input  1  lookup request this cycle.
REQ-007 SHALL have port lk_pc  input  PC_W  lookup PC.
REQ-008 SHALL have port pred_valid  output  1  prediction valid, one cycle after an accepted lookup.
REQ-009 SHALL have port pred_taken  output  1  predicted direction (counter MSB).
REQ-010 SHALL have port pred_hist  output  AB  history snapshot used for the lookup (AB = clog2(M)).
REQ-011 SHALL have port upd_valid  input  1  resolved-branch update request.
REQ-012 SHALL have port upd_pc  input  PC_W  PC of resolved branch.
REQ-013 SHALL have port upd_hist  input  AB  pred_hist returned with that branch's prediction.
REQ-014 SHALL have port upd_taken  input  1  actual outcome.
REQ-015 SHALL have port ready  output  1  table initialised; lookups/updates accepted.

Function
REQ-016 SHALL hold M independent N-bit counters; only the indexed entry changes on an update.
REQ-017 SHALL form the lookup index as lk_pc[AB-1:0] (XOR GHR when BHT_GHR_EN defined) and the update index as upd_pc[AB-1:0] (XOR upd_hist when enabled).
REQ-018 SHALL accept a lookup when lk_valid && ready; pred_valid/pred_taken/pred_hist register exactly 1 cycle later; pred_valid low otherwise.
REQ-019 SHALL accept an update when upd_valid && ready: taken -> counter+1 saturating at 2^N-1; not taken -> counter-1 saturating at 0.
REQ-020 SHALL return the pre-update counter value when a lookup and update hit the same index in the same cycle (read-old).
REQ-021 SHALL, for N=1, behave as last-outcome predictor (counter = last outcome).
REQ-022 SHALL use a two-state FSM: INIT (sweeps index 0..M-1, one entry per cycle, writing 2^(N-1)-1) and RUN; INIT->RUN after entry M-1 written, taking exactly M cycles.
REQ-023 SHALL hold ready low in INIT and high in RUN; lk_valid/upd_valid in INIT are ignored and dropped.

Reset
REQ-024 SHALL on reset: FSM -> INIT, sweep pointer 0, ready 0, pred_valid 0, pred_taken 0, pred_hist 0, GHR 0.
REQ-025 SHALL restart the sweep from entry 0 on reset asserted mid-INIT or mid-RUN; an update coincident with reset is discarded.

Configuration
REQ-026 SHALL, with BHT_GHR_EN defined, keep an AB-bit global history register shifting in upd_taken (LSB) on each accepted update, used as in REQ-017.
REQ-027 SHALL, without BHT_GHR_EN, index by PC only, drive pred_hist 0 and ignore upd_hist; ports unchanged.

Structure
REQ-028 SHALL place counter-init/max constants helper functions and the FSM state enum in shared package bht_pkg.
REQ-029 SHALL implement the counter update in one sub-module sat_ctr (N-bit saturating increment/decrement, combinational next value).

Verification
REQ-030 SHALL cover: reset, M=64 -> ready low exactly 64 cycles, then high; first lookup any pc -> pred_taken 0 (N=2 init 01).
REQ-031 SHALL cover: N=2, pc 0x005 updated taken twice -> lookup 0x005 pred_taken 1, lookup 0x006 pred_taken 0 (isolation).
REQ-032 SHALL cover: N=2, 5 taken updates then 1 not-taken -> counter 10, pred_taken 1; 3 more not-taken -> counter 00, no underflow.
REQ-033 SHALL cover: lookup and taken update to index 3 same cycle from counter 01 -> pred_taken 0 that cycle+1, next lookup 1.
REQ-034 SHALL cover: reset at INIT cycle 20 with upd_valid high -> sweep restarts, ready high 64 cycles after reset, update lost.
REQ-035 SHALL cover (BHT_GHR_EN, M=64): updates taken,taken,not-taken -> GHR 6'b000110; lookup pc 0x001 -> pred_hist 6, index 7.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared types and counter constants for the bimodal branch history table.
package bht_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Weakly-not-taken reset value for an n-bit counter: 2^(n-1)-1
  function automatic logic [3:0] ctr_init(input int unsigned n);
    return 4'((32'd1 << (n - 32'd1)) - 32'd1);
  endfunction

  // Saturation ceiling for an n-bit counter: 2^n-1
  function automatic logic [3:0] ctr_max(input int unsigned n);
    return 4'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/bht_sat_ctr.sv
// N-bit saturating up/down counter, combinational next value.
module sat_ctr
  import bht_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] ctr,
  input  logic         inc,
  output logic [N-1:0] nxt_c
);

  localparam logic [N-1:0] CTR_MAX = N'(ctr_max(N));

  always_comb begin
    nxt_c = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) nxt_c = ctr + N'(1);
    end else begin
      if (ctr != '0) nxt_c = ctr - N'(1);
    end
  end

endmodule

// File: rtl/bht_sat.sv
// Branch history table of saturating counters with an init sweep after reset.
// Optional global-history indexing (gshare style) enabled by BHT_GHR_EN.
module bht_sat
  import bht_pkg::*;
#(
  parameter int unsigned M    = 64,
  parameter int unsigned N    = 2,
  parameter int unsigned PC_W = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lk_valid,
  input  logic [PC_W-1:0]          lk_pc,
  output logic                     pred_valid,
  output logic                     pred_taken,
  output logic [$clog2(M)-1:0]     pred_hist,
  input  logic                     upd_valid,
  input  logic [PC_W-1:0]          upd_pc,
  input  logic [$clog2(M)-1:0]     upd_hist,
  input  logic                     upd_taken,
  output logic                     ready
);

  localparam int unsigned  AB       = $clog2(M);
  localparam logic [N-1:0] CTR_INIT = N'(ctr_init(N));

  state_e         state;
  logic [AB-1:0]  ptr;
  logic [N-1:0]   tbl [M];

  logic [AB-1:0]  lk_hist_c;
  logic [AB-1:0]  lk_idx_c;
  logic [AB-1:0]  upd_idx_c;
  logic [N-1:0]   upd_ctr_c;
  logic [N-1:0]   ctr_nxt_c;
  logic           we_c;
  logic [AB-1:0]  wa_c;
  logic [N-1:0]   wd_c;
  logic           unused_bits_c;

`ifdef BHT_GHR_EN
  logic [AB-1:0]  ghr;

  // Outcome history of accepted updates, newest outcome in the LSB
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (state == ST_RUN && upd_valid) begin
      ghr <= AB'({ghr, upd_taken});
    end
  end

  assign lk_hist_c = ghr;
  assign upd_idx_c = upd_pc[AB-1:0] ^ upd_hist;
`else
  assign lk_hist_c = '0;
  assign upd_idx_c = upd_pc[AB-1:0];
`endif

  assign lk_idx_c      = lk_pc[AB-1:0] ^ lk_hist_c;
  assign upd_ctr_c     = tbl[upd_idx_c];
  assign unused_bits_c = ^{lk_pc, upd_pc, upd_hist};

  sat_ctr #(.N(N)) u_sat_ctr (
    .ctr   (upd_ctr_c),
    .inc   (upd_taken),
    .nxt_c (ctr_nxt_c)
  );

  // Single table write port: init sweep or resolved-branch update
  always_comb begin
    we_c = 1'b0;
    wa_c = ptr;
    wd_c = CTR_INIT;
    if (!reset) begin
      if (state == ST_INIT) begin
        we_c = 1'b1;
      end else if (upd_valid) begin
        we_c = 1'b1;
        wa_c = upd_idx_c;
        wd_c = ctr_nxt_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we_c) tbl[wa_c] <= wd_c;
  end

  // Control FSM; lookups read the pre-update table contents
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      ptr        <= '0;
      ready      <= 1'b0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_hist  <= '0;
    end else if (state == ST_INIT) begin
      pred_valid <= 1'b0;
      ptr        <= ptr + AB'(1);
      if (ptr == AB'(M - 1)) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end
    end else begin
      pred_valid <= lk_valid;
      if (lk_valid) begin
        pred_taken <= tbl[lk_idx_c][N-1];
        pred_hist  <= lk_hist_c;
      end
    end
  end

endmodule

// File: tb/tb_bht_sat.sv
// Directed/scoreboard bench for bht_sat (M=64, N=2, PC_W=9); GHR checks follow BHT_GHR_EN.
module tb_bht_sat;

`ifdef BHT_GHR_EN
  localparam bit GHR = 1'b1;
`else
  localparam bit GHR = 1'b0;
`endif

  typedef struct {
    bit         v;
    bit         t;
    logic [5:0] h;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       lk_valid;
  logic [8:0] lk_pc;
  logic       pred_valid;
  logic       pred_taken;
  logic [5:0] pred_hist;
  logic       upd_valid;
  logic [8:0] upd_pc;
  logic [5:0] upd_hist;
  logic       upd_taken;
  logic       ready;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         mdl [64];
  logic [5:0] ghr_m;
  exp_t       q [$];

  always #5 clk = ~clk;

  bht_sat #(.M(64), .N(2), .PC_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_hist  (pred_hist),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_hist   (upd_hist),
    .upd_taken  (upd_taken),
    .ready      (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl[i] = 1;
    ghr_m = '0;
    q.delete();
  endtask

  // Count cycles until ready rises; caller is at posedge+1 just after reset edge
  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk(tag, 32'(cnt), 32'd64);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    lk_valid = 1'b0;
    upd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_pvalid"}, 32'(pred_valid), 32'd0);
    chk({tag, "_ptaken"}, 32'(pred_taken), 32'd0);
    chk({tag, "_phist"}, 32'(pred_hist), 32'd0);
    reset = 1'b0;
    model_reset();
    wait_ready({tag, "_init_len"});
  endtask

  // One RUN-mode cycle: drive, push expectation, clock, update model, pop and compare
  task automatic cycle(input bit lv, input logic [8:0] lp, input bit uv,
                       input logic [8:0] up, input logic [5:0] uh, input bit ut);
    exp_t e;
    int   li;
    int   ui;
    lk_valid  = lv;
    lk_pc     = lp;
    upd_valid = uv;
    upd_pc    = up;
    upd_hist  = uh;
    upd_taken = ut;
    li  = int'(lp[5:0] ^ (GHR ? ghr_m : 6'd0));
    e.v = lv;
    e.t = lv ? (mdl[li] >= 2) : 1'b0;
    e.h = lv ? (GHR ? ghr_m : 6'd0) : 6'd0;
    q.push_back(e);
    @(posedge clk);
    if (uv) begin
      ui = int'(up[5:0] ^ (GHR ? uh : 6'd0));
      if (ut) begin
        if (mdl[ui] < 3) mdl[ui]++;
      end else if (mdl[ui] > 0) begin
        mdl[ui]--;
      end
      if (GHR) ghr_m = {ghr_m[4:0], ut};
    end
    #1;
    lk_valid  = 1'b0;
    upd_valid = 1'b0;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("pred_valid", 32'(pred_valid), 32'(e.v));
      if (e.v) begin
        chk("pred_taken", 32'(pred_taken), 32'(e.t));
        chk("pred_hist", 32'(pred_hist), 32'(e.h));
      end
    end
    chk("ready_run", 32'(ready), 32'd1);
  endtask

  task automatic lookup(input logic [8:0] pc);
    cycle(1'b1, pc, 1'b0, 9'd0, 6'd0, 1'b0);
  endtask

  task automatic update(input logic [8:0] pc, input bit t);
    cycle(1'b0, 9'd0, 1'b1, pc, 6'd0, t);
  endtask

  initial begin
    reset = 1'b1;
    lk_valid = 1'b0;
    lk_pc = '0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_hist = '0;
    upd_taken = 1'b0;
    model_reset();

    // Reset, init sweep length, first lookup returns weakly-not-taken
    do_reset("rst0");
    lookup(9'h1A3);
    chk("first_lookup", 32'(pred_taken), 32'd0);
    cycle(1'b0, 9'd0, 1'b0, 9'd0, 6'd0, 1'b0);

    // Isolation: two taken updates on 0x005 do not disturb 0x006
    update(9'h005, 1'b1);
    update(9'h005, 1'b1);
    lookup(9'h005);
    chk("iso_hit", 32'(pred_taken), 32'd1);
    lookup(9'h006);
    chk("iso_neighbour", 32'(pred_taken), 32'd0);

    // Saturation at top and bottom on 0x010
    for (int i = 0; i < 5; i++) update(9'h010, 1'b1);
    update(9'h010, 1'b0);
    lookup(9'h010);
    chk("sat_hi_then_dec", 32'(pred_taken), 32'd1);
    for (int i = 0; i < 3; i++) update(9'h010, 1'b0);
    lookup(9'h010);
    chk("sat_lo", 32'(pred_taken), 32'd0);
    update(9'h010, 1'b1);
    lookup(9'h010);
    chk("no_underflow_01", 32'(pred_taken), 32'd0);
    update(9'h010, 1'b1);
    lookup(9'h010);
    chk("no_underflow_10", 32'(pred_taken), 32'd1);

    // Same-cycle lookup and taken update on index 3 reads the old value
    cycle(1'b1, 9'h003, 1'b1, 9'h003, 6'd0, 1'b1);
    chk("read_old", 32'(pred_taken), 32'd0);
    lookup(9'h003);
    chk("read_after", 32'(pred_taken), 32'd1);

    // Random mix on aliasing PCs
    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom_range(0, 1)), {3'($urandom), 3'b0, 3'($urandom)},
            1'($urandom_range(0, 1)), {3'($urandom), 3'b0, 3'($urandom)},
            6'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset mid-RUN reinitialises a trained entry
    update(9'h005, 1'b1);
    update(9'h005, 1'b1);
    do_reset("rst_run");
    lookup(9'h005);
    chk("rst_run_entry", 32'(pred_taken), 32'd0);

    // Reset at INIT cycle 20 with lookup/update pending
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("init20_ready", 32'(ready), 32'd0);
    chk("init20_pvalid", 32'(pred_valid), 32'd0);
    reset = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 9'h020;
    upd_taken = 1'b1;
    lk_valid = 1'b1;
    lk_pc = 9'h020;
    @(posedge clk);
    #1;
    chk("rst_init_ready", 32'(ready), 32'd0);
    chk("rst_init_pvalid", 32'(pred_valid), 32'd0);
    reset = 1'b0;
    upd_valid = 1'b0;
    lk_valid = 1'b0;
    wait_ready("rst_init_len");
    lookup(9'h020);
    chk("rst_init_upd_lost", 32'(pred_taken), 32'd0);

    // History: taken, taken, not-taken then lookup pc 0x001
    do_reset("rst_ghr");
    update(9'h007, 1'b1);
    update(9'h007, 1'b1);
    update(9'h030, 1'b0);
    lookup(9'h001);
`ifdef BHT_GHR_EN
    chk("ghr_hist", 32'(pred_hist), 32'd6);
    chk("ghr_index7", 32'(pred_taken), 32'd1);
`else
    chk("nohist_hist", 32'(pred_hist), 32'd0);
    chk("nohist_index1", 32'(pred_taken), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
